// File: rtl/time_prog_pkg.sv
// Shared types and helpers for the multi-field BCD time programmer.
package time_prog_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EDIT = 2'd1,
    DONE = 2'd2
  } prog_state_t;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t tens;
    bcd_digit_t units;
  } bcd_field_t;

  // Binary value (0..99) to a two-digit BCD field.
  function automatic bcd_field_t to_bcd(input int unsigned v);
    bcd_field_t r;
    r.tens  = 4'(v / 10);
    r.units = 4'(v % 10);
    return r;
  endfunction

  // Wrap limit for a field index: the top field has its own limit.
  function automatic bcd_field_t field_max(input int unsigned idx, input int unsigned nf,
                                           input int unsigned low, input int unsigned top);
    return (idx == nf - 1) ? to_bcd(top) : to_bcd(low);
  endfunction

endpackage

// File: rtl/bcd_field_counter.sv
// One two-digit BCD field with wrap-around increment/decrement and clear.
module bcd_field_counter
  import time_prog_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_inc,
  input  logic       i_dec,
  input  logic       i_clr,
  input  bcd_field_t i_max,
  output bcd_field_t o_value
);

  bcd_field_t r_value;
  bcd_field_t w_inc_val;
  bcd_field_t w_dec_val;

  // Next values for +1 and -1, computed per digit so only legal BCD is ever stored.
  always_comb begin
    w_inc_val = r_value;
    w_dec_val = r_value;
    if (r_value == i_max) begin
      w_inc_val = '0;
    end else if (r_value.units == 4'd9) begin
      w_inc_val.tens  = r_value.tens + 4'd1;
      w_inc_val.units = 4'd0;
    end else begin
      w_inc_val.units = r_value.units + 4'd1;
    end
    if (r_value == bcd_field_t'(8'h00)) begin
      w_dec_val = i_max;
    end else if (r_value.units == 4'd0) begin
      w_dec_val.tens  = r_value.tens - 4'd1;
      w_dec_val.units = 4'd9;
    end else begin
      w_dec_val.units = r_value.units - 4'd1;
    end
  end

  // Field register: clear wins, then increment, then decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
    end else if (i_clr) begin
      r_value <= '0;
    end else if (i_inc) begin
      r_value <= w_inc_val;
    end else if (i_dec) begin
      r_value <= w_dec_val;
    end
  end

  assign o_value = r_value;

endmodule

// File: rtl/time_programmer.sv
// Edits 1-3 BCD time fields with step, auto-repeat, blink and a completion pulse.
module time_programmer
  import time_prog_pkg::*;
#(
  parameter logic [2:0]  STATE_ID      = 3'd1,
  parameter int unsigned NUM_FIELDS    = 2,
  parameter int unsigned LOW_MAX       = 59,
  parameter int unsigned TOP_MAX       = 59,
  parameter int unsigned REPEAT_DELAY  = 500000,
  parameter int unsigned REPEAT_PERIOD = 100000,
  parameter int unsigned BLINK_HALF    = 250000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [2:0]                current_state,
  input  logic                      toggle,
  input  logic                      increase,
  input  logic                      decrease,
  output logic [8*NUM_FIELDS-1:0]   digits_out,
  output logic [NUM_FIELDS-1:0]     blink_mask,
  output logic                      programmed
);

  localparam int unsigned SW     = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int unsigned REP_MX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CW     = $clog2(REP_MX + 1);
  localparam int unsigned BW     = $clog2(BLINK_HALF + 1);
  localparam logic [SW-1:0] LAST_SEL = SW'(NUM_FIELDS - 1);

  prog_state_t     r_state;
  logic [SW-1:0]   r_sel;
  logic [2:0]      r_prev_state;
  logic            r_inc_only_d;
  logic            r_dec_only_d;
  logic [CW-1:0]   r_rep;
  logic            r_rep_first;
  logic [BW-1:0]   r_bcnt;
  logic            r_phase;
  logic [NUM_FIELDS-1:0] r_blink_mask;
  logic            r_programmed;

  logic            w_active, w_entry, w_edit;
  logic            w_inc_only, w_dec_only;
  logic            w_hold, w_press, w_rep_hit, w_step, w_restart;
  logic [BW-1:0]   w_bcnt_nxt;
  logic            w_phase_nxt;
  logic [NUM_FIELDS-1:0] w_mask_nxt, w_fld_inc, w_fld_dec;
  bcd_field_t      w_fields [NUM_FIELDS];

  // Entry detection, step/repeat decisions, blink phase and per-field strobes.
  always_comb begin
    w_active   = (current_state == STATE_ID);
    w_entry    = w_active && (r_prev_state != STATE_ID);
    w_edit     = w_active && !w_entry && (r_state == EDIT);
    w_inc_only = increase && !decrease;
    w_dec_only = decrease && !increase;
    w_hold     = w_edit && !toggle && (w_inc_only || w_dec_only);
    w_press    = w_hold && ((w_inc_only && !r_inc_only_d) || (w_dec_only && !r_dec_only_d));
    w_rep_hit  = w_hold && !w_press &&
                 (r_rep == (r_rep_first ? CW'(REPEAT_DELAY) : CW'(REPEAT_PERIOD)));
    w_step     = w_press || w_rep_hit;
    w_restart  = !w_edit || toggle || w_step;
    w_bcnt_nxt  = '0;
    w_phase_nxt = 1'b0;
    if (!w_restart) begin
      if (r_bcnt == BW'(BLINK_HALF - 1)) begin
        w_phase_nxt = !r_phase;
      end else begin
        w_bcnt_nxt  = r_bcnt + BW'(1);
        w_phase_nxt = r_phase;
      end
    end
    w_mask_nxt = '0;
    w_fld_inc  = '0;
    w_fld_dec  = '0;
    for (int i = 0; i < int'(NUM_FIELDS); i++) begin
      w_fld_inc[i]  = w_step && w_inc_only && (r_sel == SW'(i));
      w_fld_dec[i]  = w_step && w_dec_only && (r_sel == SW'(i));
      w_mask_nxt[i] = w_phase_nxt && (r_sel == SW'(i));
    end
  end

  // Control FSM with field selection, repeat timer, blink timer and registered flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_sel        <= '0;
      r_prev_state <= '0;
      r_inc_only_d <= 1'b0;
      r_dec_only_d <= 1'b0;
      r_rep        <= '0;
      r_rep_first  <= 1'b0;
      r_bcnt       <= '0;
      r_phase      <= 1'b0;
      r_blink_mask <= '0;
      r_programmed <= 1'b0;
    end else begin
      r_prev_state <= current_state;
      r_inc_only_d <= w_inc_only;
      r_dec_only_d <= w_dec_only;
      r_bcnt       <= w_bcnt_nxt;
      r_phase      <= w_phase_nxt;
      r_blink_mask <= w_mask_nxt;
      r_programmed <= w_edit && toggle && (r_sel == LAST_SEL);

      if (!w_active) begin
        r_state <= IDLE;
      end else if (w_entry) begin
        r_state <= EDIT;
        r_sel   <= '0;
      end else if (w_edit && toggle) begin
        if (r_sel < LAST_SEL) begin
          r_sel <= r_sel + SW'(1);
        end else begin
          r_state <= DONE;
        end
      end

      if (!w_hold) begin
        r_rep       <= '0;
        r_rep_first <= 1'b1;
      end else if (w_step) begin
        r_rep       <= CW'(1);
        r_rep_first <= w_press;
      end else begin
        r_rep <= r_rep + CW'(1);
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_FIELDS); g++) begin : g_field
    localparam int unsigned IDX = g;
    bcd_field_counter u_field (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_inc   (w_fld_inc[g]),
      .i_dec   (w_fld_dec[g]),
      .i_clr   (w_entry),
      .i_max   (field_max(IDX, NUM_FIELDS, LOW_MAX, TOP_MAX)),
      .o_value (w_fields[g])
    );
    assign digits_out[8*g +: 8] = w_fields[g];
  end

  assign blink_mask = r_blink_mask;
  assign programmed = r_programmed;

endmodule

// File: tb/tb_time_programmer.sv
// Bench for time_programmer: directed scenarios plus random editing against a field-level model.
module tb_time_programmer;

  localparam int NF = 2;
  localparam int LOW = 59;
  localparam int TOP = 23;
  localparam int D = 4;
  localparam int P = 2;
  localparam int BH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  current_state;
  logic        toggle, increase, decrease;
  logic [15:0] digits_out;
  logic [1:0]  blink_mask;
  logic        programmed;

  int n_chk = 0;
  int n_fail = 0;

  // Model state: binary field values, selected field, mode 0 idle / 1 edit / 2 done.
  int m_f [NF];
  int m_sel, m_mode, m_prev_cs, m_prevcur, m_age, m_bage;
  bit m_prog;

  time_programmer #(
    .STATE_ID(3'd1), .NUM_FIELDS(NF), .LOW_MAX(LOW), .TOP_MAX(TOP),
    .REPEAT_DELAY(D), .REPEAT_PERIOD(P), .BLINK_HALF(BH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .current_state(current_state), .toggle(toggle),
    .increase(increase), .decrease(decrease), .digits_out(digits_out),
    .blink_mask(blink_mask), .programmed(programmed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] bcd8(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic logic [1:0] exp_mask();
    if (m_mode == 1 && ((m_bage / BH) % 2) == 1) return 2'(1 << m_sel);
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_f[0] = 0; m_f[1] = 0;
    m_sel = 0; m_mode = 0; m_prev_cs = 0; m_prevcur = 0; m_age = 0; m_bage = 0;
    m_prog = 0;
  endtask

  task automatic model_apply(input bit up);
    int mx;
    mx = (m_sel == NF - 1) ? TOP : LOW;
    if (up) m_f[m_sel] = (m_f[m_sel] == mx) ? 0 : m_f[m_sel] + 1;
    else    m_f[m_sel] = (m_f[m_sel] == 0) ? mx : m_f[m_sel] - 1;
  endtask

  // One clock of behaviour, from the inputs sampled at this edge.
  task automatic model_step();
    int cs, cur;
    bit active, entry, restart;
    cs = int'(current_state);
    active = (cs == 1);
    entry = active && (m_prev_cs != 1);
    cur = (increase && !decrease) ? 1 : ((decrease && !increase) ? 2 : 0);
    restart = 0;
    m_prog = 0;
    if (!active) begin
      m_mode = 0;
    end else if (entry) begin
      m_f[0] = 0; m_f[1] = 0; m_sel = 0; m_mode = 1; restart = 1;
    end else if (m_mode == 1) begin
      if (toggle) begin
        restart = 1;
        if (m_sel < NF - 1) m_sel++;
        else begin m_mode = 2; m_prog = 1; end
      end else if (cur != 0) begin
        if (cur != m_prevcur) m_age = 0;
        else m_age++;
        if (m_age == 0 || (m_age >= D && ((m_age - D) % P) == 0)) begin
          restart = 1;
          model_apply(cur == 1);
        end
      end
    end
    m_prevcur = cur;
    m_prev_cs = cs;
    m_bage = restart ? 0 : m_bage + 1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    check("digits", 32'(digits_out), 32'({bcd8(m_f[1]), bcd8(m_f[0])}));
    check("blink_mask", 32'(blink_mask), 32'(exp_mask()));
    check("programmed", 32'(programmed), 32'(m_prog));
  endtask

  task automatic press(input bit up, input int len, input int gap);
    if (up) increase = 1'b1; else decrease = 1'b1;
    repeat (len) tick();
    increase = 1'b0; decrease = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic reenter();
    current_state = 3'd0; tick();
    current_state = 3'd1; tick();
    tick();
  endtask

  initial begin
    int act, v;
    rst_n = 1'b0; current_state = 3'd0; toggle = 1'b0; increase = 1'b0; decrease = 1'b0;
    model_reset();
    #12;
    check("reset_digits", 32'(digits_out), 32'h0);
    check("reset_mask", 32'(blink_mask), 32'h0);
    check("reset_prog", 32'(programmed), 32'h0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Entry clears fields, then preload 12:34 and re-enter.
    current_state = 3'd1; tick();
    check("entry_clear", 32'(digits_out), 32'h0000);
    tick();
    repeat (34) press(1'b1, 1, 1);
    toggle = 1'b1; tick(); toggle = 1'b0; tick();
    repeat (12) press(1'b1, 1, 1);
    check("preload", 32'(digits_out), 32'h1234);
    current_state = 3'd0; tick(); tick();
    check("held_on_exit", 32'(digits_out), 32'h1234);
    current_state = 3'd1; tick();
    check("reentry_clear", 32'(digits_out), 32'h0000);
    tick();

    // Wrap at both limits on both fields.
    press(1'b0, 1, 1); check("f0_dec_wrap", 32'(digits_out), 32'h0059);
    press(1'b1, 1, 1); check("f0_inc_wrap", 32'(digits_out), 32'h0000);
    press(1'b0, 1, 1); check("f0_dec_again", 32'(digits_out), 32'h0059);
    toggle = 1'b1; tick(); toggle = 1'b0; tick();
    press(1'b0, 1, 1); check("f1_dec_wrap", 32'(digits_out), 32'h2359);
    press(1'b1, 1, 1); check("f1_inc_wrap", 32'(digits_out), 32'h0059);

    // Auto-repeat from 00.
    reenter();
    increase = 1'b1; repeat (11) tick(); increase = 1'b0;
    check("repeat_end", 32'(digits_out), 32'h0005);
    repeat (3) tick();
    check("repeat_stop", 32'(digits_out), 32'h0005);

    // Toggle wins over a simultaneous step edge.
    toggle = 1'b1; increase = 1'b1; tick(); toggle = 1'b0; increase = 1'b0;
    check("tog_inc_nostep", 32'(digits_out), 32'h0005);
    tick();
    press(1'b1, 1, 1); check("sel1_step", 32'(digits_out), 32'h0105);

    // Both step inputs high, then release one.
    increase = 1'b1; decrease = 1'b1; repeat (6) tick();
    check("both_high", 32'(digits_out), 32'h0105);
    decrease = 1'b0; tick();
    check("release_one", 32'(digits_out), 32'h0205);
    increase = 1'b0; tick();

    // Final toggle completes; DONE ignores further input.
    toggle = 1'b1; tick(); toggle = 1'b0;
    check("prog_pulse", 32'(programmed), 32'h1);
    tick();
    check("prog_single", 32'(programmed), 32'h0);
    press(1'b1, 1, 1); check("done_frozen", 32'(digits_out), 32'h0205);
    toggle = 1'b1; tick(); toggle = 1'b0;
    check("done_no_pulse", 32'(programmed), 32'h0);

    // Exit mid-edit and re-enter.
    reenter();
    press(1'b1, 1, 1);
    current_state = 3'd2; tick();
    check("exit_prog", 32'(programmed), 32'h0);
    check("exit_mask", 32'(blink_mask), 32'h0);
    current_state = 3'd1; tick();
    check("exit_reenter_clear", 32'(digits_out), 32'h0000);

    // Idle in EDIT to watch the blink.
    repeat (20) tick();

    // Async reset in the middle of auto-repeat.
    increase = 1'b1; repeat (7) tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_digits", 32'(digits_out), 32'h0);
    check("async_rst_mask", 32'(blink_mask), 32'h0);
    check("async_rst_prog", 32'(programmed), 32'h0);
    tick();
    increase = 1'b0; rst_n = 1'b1;
    tick(); tick();

    // Random editing sessions.
    repeat (300) begin
      act = int'($urandom_range(0, 9));
      case (act)
        0, 1, 2: press(1'b1, int'($urandom_range(1, 12)), int'($urandom_range(1, 3)));
        3, 4:    press(1'b0, int'($urandom_range(1, 12)), int'($urandom_range(1, 3)));
        5: begin
          increase = 1'b1; repeat ($urandom_range(1, 3)) tick();
          decrease = 1'b1; repeat ($urandom_range(1, 3)) tick();
          if ($urandom_range(0, 1) == 1) increase = 1'b0; else decrease = 1'b0;
          repeat ($urandom_range(1, 8)) tick();
          increase = 1'b0; decrease = 1'b0; tick();
        end
        6, 7: begin
          toggle = 1'b1; tick(); toggle = 1'b0; tick();
        end
        8: begin
          v = int'($urandom_range(0, 6));
          if (v >= 1) v++;
          current_state = 3'(v);
          repeat ($urandom_range(1, 3)) tick();
          current_state = 3'd1; tick(); tick();
        end
        default: repeat ($urandom_range(1, 10)) tick();
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
